// File: rtl/arm_mdu_pkg.sv
// Shared types and op encodings for the multiply unit and the instruction decoder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package arm_mdu_pkg;

   // Op encodings, also used by the decoder when it drives the unit
   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MLA   = 2'b01;
   localparam logic [1:0] OP_UMULL = 2'b10;
   localparam logic [1:0] OP_SMULL = 2'b11;

   typedef enum logic [1:0] {
      MUL   = OP_MUL,
      MLA   = OP_MLA,
      UMULL = OP_UMULL,
      SMULL = OP_SMULL
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

   // Long ops return a full double-width product and flag on the high word
   function automatic logic is_long(input mdu_op_t op);
      return (op == UMULL) || (op == SMULL);
   endfunction

endpackage

// File: rtl/arm_mdu_if.sv
// Controller-to-multiplier bus: request, operands, status and result.
// Latency: none (wiring only).
// Backpressure: controller holds off while busy is high; start during busy is dropped.
interface arm_mdu_if #(parameter int WIDTH = 32);
   import arm_mdu_pkg::*;

   logic             start;
   logic             flush;
   mdu_op_t          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic [1:0]       flags;

   modport master (
      output start, flush, op, a, b, acc,
      input  busy, done, result_lo, result_hi, flags
   );

   modport slave (
      input  start, flush, op, a, b, acc,
      output busy, done, result_lo, result_hi, flags
   );
endinterface

// File: rtl/arm_mdu_step.sv
// One radix-2^BPC add-and-shift step of the product register.
// Latency: combinational.
// Backpressure: none.
module arm_mdu_step #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic [2*WIDTH-BPC-1:0] p_in,    // product register with its low BPC bits already dropped
   input  logic [WIDTH-1:0]       mcand,
   input  logic [BPC-1:0]         digit,
   output logic [2*WIDTH-1:0]     p_out
);
   localparam int SW = WIDTH + BPC;

   // Upper half never exceeds mcand, so upper + mcand*digit fits in WIDTH+BPC bits
   logic [SW-1:0] sum;

   // Add the partial product into the upper half, then shift the whole register right by BPC
   always_comb begin
      sum   = SW'(p_in[2*WIDTH-BPC-1:WIDTH-BPC]) + SW'(mcand) * SW'(digit);
      p_out = {sum, p_in[WIDTH-BPC-1:0]};
   end
endmodule

// File: rtl/arm_mdu.sv
// Iterative MUL/MLA/UMULL/SMULL unit with start/busy/done handshake and N/Z flags.
// Latency: done pulses WIDTH/BPC + 1 edges after the accept edge.
// Backpressure: busy high while running; start ignored unless idle; flush aborts without done.
module arm_mdu
   import arm_mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input logic      clk,
   input logic      reset,
   arm_mdu_if.slave bus
);
   localparam int STEPS = WIDTH / BPC;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   mdu_state_t         state, state_nxt;
   mdu_op_t            op_q;
   logic [WIDTH-1:0]   mcand, mplier, acc_q;
   logic               sign_q;
   logic [2*WIDTH-1:0] prod, prod_step, final_p;
   logic [CW-1:0]      cnt;
   logic               accept, fix_fire, req_smull;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   lo_nxt, hi_nxt;
   logic               n_nxt, z_nxt;
   logic [WIDTH-1:0]   res_lo, res_hi;
   logic [1:0]         flags_q;
   logic               done_q;

   // SMULL runs on magnitudes; the most-negative value maps to 2^(W-1), still exact unsigned
   assign req_smull = (bus.op == SMULL);
   assign a_mag     = (req_smull && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag     = (req_smull && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   arm_mdu_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
      .p_in  (prod[2*WIDTH-1:BPC]),
      .mcand (mcand),
      .digit (mplier[BPC-1:0]),
      .p_out (prod_step)
   );

   // Next-state decode: flush beats start in IDLE and beats completion in RUN/FIX
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fix_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               state_nxt = RUN;
               accept    = 1'b1;
            end
         end
         RUN: begin
            if (bus.flush)                   state_nxt = IDLE;
            else if (cnt == CW'(STEPS - 1))  state_nxt = FIX;
         end
         FIX: begin
            state_nxt = IDLE;
            fix_fire  = !bus.flush;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Final fix-up: restore sign, add accumulator, pick flag source word
   always_comb begin
      final_p = sign_q ? -prod : prod;
      lo_nxt  = final_p[WIDTH-1:0];
      hi_nxt  = '0;
      n_nxt   = 1'b0;
      z_nxt   = 1'b0;
      if (op_q == MLA) lo_nxt = final_p[WIDTH-1:0] + acc_q;
      if (is_long(op_q)) begin
         hi_nxt = final_p[2*WIDTH-1:WIDTH];
         n_nxt  = final_p[2*WIDTH-1];
         z_nxt  = (final_p == '0);
      end else begin
         n_nxt  = lo_nxt[WIDTH-1];
         z_nxt  = (lo_nxt == '0);
      end
   end

   // Operand latch on accept, add-and-shift in RUN, result capture on an unflushed FIX edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q    <= MUL;
         mcand   <= '0;
         mplier  <= '0;
         acc_q   <= '0;
         sign_q  <= 1'b0;
         prod    <= '0;
         cnt     <= '0;
         res_lo  <= '0;
         res_hi  <= '0;
         flags_q <= 2'b00;
         done_q  <= 1'b0;
      end else begin
         done_q <= fix_fire;
         if (accept) begin
            op_q   <= bus.op;
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_q  <= bus.acc;
            sign_q <= req_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            prod   <= '0;
            cnt    <= '0;
         end else if (state == RUN) begin
            prod   <= prod_step;
            mplier <= mplier >> BPC;
            cnt    <= cnt + CW'(1);
         end
         if (fix_fire) begin
            res_lo  <= lo_nxt;
            res_hi  <= hi_nxt;
            flags_q <= {n_nxt, z_nxt};
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.result_lo = res_lo;
   assign bus.result_hi = res_hi;
   assign bus.flags     = flags_q;
endmodule

// File: tb/tb_arm_mdu.sv
// Scoreboarded random/directed bench for arm_mdu at radix 2 and radix 16.
// Latency: expects done WIDTH/BPC + 1 edges after accept.
// Backpressure: issues only when the unit is idle or in its done cycle, except deliberate busy starts.
module tb_arm_mdu;
   import arm_mdu_pkg::*;

   localparam int W  = 32;
   localparam int S1 = 32;   // steps at BPC=1
   localparam int S4 = 8;    // steps at BPC=4

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic [1:0]   flags;
      int           cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t q1[$];
   exp_t q4[$];
   exp_t last1;

   arm_mdu_if #(.WIDTH(W)) if1 ();
   arm_mdu_if #(.WIDTH(W)) if4 ();

   arm_mdu #(.WIDTH(W), .BPC(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   arm_mdu #(.WIDTH(W), .BPC(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain full-width arithmetic on the architectural operand meaning
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] acc);
      exp_t        e;
      logic [63:0] full;
      longint      sa, sb;
      full = {32'h0, a} * {32'h0, b};
      e.hi = '0;
      e.lo = full[31:0];
      e.cyc = 0;
      case (op)
         2'b01: e.lo = full[31:0] + acc;
         2'b10: {e.hi, e.lo} = full;
         2'b11: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            full = 64'(sa * sb);
            {e.hi, e.lo} = full;
         end
         default: ;
      endcase
      if (op[1]) e.flags = {e.hi[31], ({e.hi, e.lo} == 64'h0)};
      else       e.flags = {e.lo[31], (e.lo == 32'h0)};
      return e;
   endfunction

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Drive a request at the current negedge, drop start at the next, then scramble operands
   task automatic issue(input bit use4, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] acc, input bit expect_res);
      exp_t e;
      e = model(op, a, b, acc);
      if (use4) begin
         if4.start = 1'b1; if4.op = mdu_op_t'(op); if4.a = a; if4.b = b; if4.acc = acc;
         e.cyc = cyc + S4 + 2;
         if (expect_res) q4.push_back(e);
      end else begin
         if1.start = 1'b1; if1.op = mdu_op_t'(op); if1.a = a; if1.b = b; if1.acc = acc;
         e.cyc = cyc + S1 + 2;
         if (expect_res) begin
            q1.push_back(e);
            last1 = e;
         end
      end
      @(negedge clk);
      if (use4) begin
         if4.start = 1'b0; if4.a = $urandom; if4.b = $urandom; if4.acc = $urandom;
      end else begin
         if1.start = 1'b0; if1.a = $urandom; if1.b = $urandom; if1.acc = $urandom;
      end
   endtask

   task automatic wait_idle(input bit use4);
      int n;
      n = 0;
      while ((use4 ? if4.busy : if1.busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", n);
      end
   endtask

   // Monitor for the radix-2 unit: result, done timing and busy span
   initial begin : mon1
      exp_t e;
      int   brun;
      brun = 0;
      forever begin
         @(negedge clk);
         if (if1.done) begin
            if (q1.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL bpc1 unexpected done: got done=1 required 0 (cycle %0d)", cyc);
            end else begin
               e = q1.pop_front();
               chk("bpc1 lo", 64'(if1.result_lo), 64'(e.lo));
               chk("bpc1 hi", 64'(if1.result_hi), 64'(e.hi));
               chk("bpc1 flags", 64'(if1.flags), 64'(e.flags));
               chk("bpc1 done cycle", 64'(cyc), 64'(e.cyc));
               chk("bpc1 busy span", 64'(brun), 64'(S1 + 1));
            end
         end
         if (if1.busy) brun++;
         else          brun = 0;
      end
   end

   // Monitor for the radix-16 unit
   initial begin : mon4
      exp_t e;
      int   brun;
      brun = 0;
      forever begin
         @(negedge clk);
         if (if4.done) begin
            if (q4.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL bpc4 unexpected done: got done=1 required 0 (cycle %0d)", cyc);
            end else begin
               e = q4.pop_front();
               chk("bpc4 lo", 64'(if4.result_lo), 64'(e.lo));
               chk("bpc4 hi", 64'(if4.result_hi), 64'(e.hi));
               chk("bpc4 flags", 64'(if4.flags), 64'(e.flags));
               chk("bpc4 done cycle", 64'(cyc), 64'(e.cyc));
               chk("bpc4 busy span", 64'(brun), 64'(S4 + 1));
            end
         end
         if (if4.busy) brun++;
         else          brun = 0;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [1:0]   dop [6];
      logic [W-1:0] da  [6];
      logic [W-1:0] db  [6];
      logic [W-1:0] dacc[6];
      exp_t         prev;

      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      if1.start = 1'b0; if1.flush = 1'b0; if1.op = MUL; if1.a = '0; if1.b = '0; if1.acc = '0;
      if4.start = 1'b0; if4.flush = 1'b0; if4.op = MUL; if4.a = '0; if4.b = '0; if4.acc = '0;

      dop[0] = 2'b00; da[0] = 32'd7;         db[0] = 32'd6;         dacc[0] = 32'd0;
      dop[1] = 2'b01; da[1] = 32'd3;         db[1] = 32'd5;         dacc[1] = 32'd100;
      dop[2] = 2'b00; da[2] = 32'h0001_0000; db[2] = 32'h0001_0000; dacc[2] = 32'd0;
      dop[3] = 2'b10; da[3] = 32'hFFFF_FFFF; db[3] = 32'hFFFF_FFFF; dacc[3] = 32'd0;
      dop[4] = 2'b11; da[4] = 32'hFFFF_FFFF; db[4] = 32'd2;         dacc[4] = 32'd0;
      dop[5] = 2'b11; da[5] = 32'h8000_0000; db[5] = 32'h8000_0000; dacc[5] = 32'd0;

      repeat (2) @(negedge clk);
      chk("reset busy", 64'(if1.busy), 64'h0);
      chk("reset done", 64'(if1.done), 64'h0);
      chk("reset lo", 64'(if1.result_lo), 64'h0);
      chk("reset hi", 64'(if1.result_hi), 64'h0);
      chk("reset flags", 64'(if1.flags), 64'h0);
      chk("reset bpc4 busy", 64'(if4.busy), 64'h0);
      reset = 1'b1;
      @(negedge clk);

      // Directed vectors on both radices
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, dop[i], da[i], db[i], dacc[i], 1'b1);
         wait_idle(1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int i = 0; i < 6; i++) begin
         issue(1'b1, dop[i], da[i], db[i], dacc[i], 1'b1);
         wait_idle(1'b1);
      end

      // Random ops; a zero gap means the next start lands in the done cycle
      for (int i = 0; i < 12; i++) begin
         issue(1'b0, 2'($urandom_range(0, 3)), pick_val(), pick_val(), $urandom, 1'b1);
         wait_idle(1'b0);
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      for (int i = 0; i < 16; i++) begin
         issue(1'b1, 2'($urandom_range(0, 3)), pick_val(), pick_val(), $urandom, 1'b1);
         wait_idle(1'b1);
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end

      // Start while busy must be dropped
      issue(1'b0, 2'b10, $urandom, $urandom, 32'h0, 1'b1);
      repeat (8) @(negedge clk);
      if1.start = 1'b1; if1.op = SMULL; if1.a = $urandom; if1.b = $urandom;
      @(negedge clk);
      if1.start = 1'b0;
      wait_idle(1'b0);
      repeat (3) @(negedge clk);

      // Flush mid-run: no done, outputs keep the previous result
      prev = last1;
      issue(1'b0, 2'b00, 32'd12345, 32'd777, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      if1.flush = 1'b1;
      @(negedge clk);
      if1.flush = 1'b0;
      chk("flush busy", 64'(if1.busy), 64'h0);
      chk("flush done", 64'(if1.done), 64'h0);
      repeat (40) @(negedge clk);
      chk("flush keeps lo", 64'(if1.result_lo), 64'(prev.lo));
      chk("flush keeps hi", 64'(if1.result_hi), 64'(prev.hi));
      chk("flush keeps flags", 64'(if1.flags), 64'(prev.flags));

      // Flush together with start in IDLE: nothing accepted
      if1.start = 1'b1; if1.flush = 1'b1; if1.op = MUL; if1.a = 32'd9; if1.b = 32'd9;
      @(negedge clk);
      if1.start = 1'b0; if1.flush = 1'b0;
      chk("flush+start busy", 64'(if1.busy), 64'h0);
      repeat (40) @(negedge clk);
      chk("flush+start keeps lo", 64'(if1.result_lo), 64'(prev.lo));

      // Asynchronous reset in the middle of a run
      issue(1'b0, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b0);
      repeat (18) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async reset busy", 64'(if1.busy), 64'h0);
      chk("async reset done", 64'(if1.done), 64'h0);
      chk("async reset lo", 64'(if1.result_lo), 64'h0);
      chk("async reset hi", 64'(if1.result_hi), 64'h0);
      chk("async reset flags", 64'(if1.flags), 64'h0);
      chk("async reset bpc4 lo", 64'(if4.result_lo), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Recovery after reset
      issue(1'b0, 2'b01, pick_val(), pick_val(), $urandom, 1'b1);
      wait_idle(1'b0);
      repeat (5) @(negedge clk);

      chk("bpc1 queue drained", 64'(q1.size()), 64'h0);
      chk("bpc4 queue drained", 64'(q4.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
